// File: rtl/insn_addr_gen_pkg.sv
// Shared definitions for the fetch address generator: FSM state encoding
// and default instruction-memory address width.
package insn_addr_gen_pkg;

   localparam int unsigned DEF_MEM_INSN_ADDR = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/insn_addr_gen.sv
// Fetch address generator: registered PC stepped by a small FSM, with
// redirect (one-cycle flush), halt and fetcher back-pressure handling.
module insn_addr_gen
   import insn_addr_gen_pkg::*;
#(
   parameter int unsigned                   MEM_INSN_ADDR = DEF_MEM_INSN_ADDR,
   parameter logic [MEM_INSN_ADDR-1:0]      RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     stall_i,
   input  logic                     halt_i,
   input  logic                     redirect_valid_i,
   input  logic [MEM_INSN_ADDR-1:0] redirect_addr_i,
   output logic                     valid_o,
   output logic [MEM_INSN_ADDR-1:0] addr_o,
   output logic                     flush_o,
   output logic                     busy_o
);

   fetch_state_t             r_state;
   fetch_state_t             w_state_nxt;
   logic [MEM_INSN_ADDR-1:0] r_pc;
   logic [MEM_INSN_ADDR-1:0] w_pc_nxt;
   logic                     r_flush;
   logic                     w_flush_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_flush <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_flush <= w_flush_nxt;
      end
   end

   // Redirect outranks halt (older instruction), and both outrank stall.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_flush_nxt = 1'b0;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
               w_pc_nxt    = RESET_PC;
            end
         end
         ST_RUN: begin
            if (redirect_valid_i) begin
               w_pc_nxt    = redirect_addr_i;
               w_flush_nxt = 1'b1;
            end else if (halt_i) begin
               w_state_nxt = ST_HALTED;
            end else if (!stall_i) begin
               w_pc_nxt = r_pc + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = RESET_PC;
         end
      endcase
   end

   always_comb begin
      valid_o = (r_state == ST_RUN);
      busy_o  = (r_state == ST_RUN);
      addr_o  = r_pc;
      flush_o = r_flush;
   end

endmodule

// File: tb/tb_insn_addr_gen.sv
// Self-checking bench for insn_addr_gen: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_insn_addr_gen;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          stall_i;
   logic          halt_i;
   logic          redirect_valid_i;
   logic [AW-1:0] redirect_addr_i;
   logic          valid_o;
   logic [AW-1:0] addr_o;
   logic          flush_o;
   logic          busy_o;

   int checks = 0;
   int errors = 0;

   // Behavioural model: "fetching or not", plain-integer pc, flush flag.
   bit m_fetching;
   int m_pc;
   bit m_flush;

   insn_addr_gen #(
      .MEM_INSN_ADDR (AW),
      .RESET_PC      (10'h000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start_i),
      .stall_i          (stall_i),
      .halt_i           (halt_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_addr_i  (redirect_addr_i),
      .valid_o          (valid_o),
      .addr_o           (addr_o),
      .flush_o          (flush_o),
      .busy_o           (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit flush_n;
      flush_n = 1'b0;
      if (rst) begin
         m_fetching = 1'b0;
         m_pc       = 0;
      end else if (!m_fetching) begin
         if (start_i) begin
            m_fetching = 1'b1;
            m_pc       = 0;
         end
      end else if (redirect_valid_i) begin
         m_pc    = int'(redirect_addr_i);
         flush_n = 1'b1;
      end else if (halt_i) begin
         m_fetching = 1'b0;
      end else if (!stall_i) begin
         m_pc = (m_pc + 1) % (1 << AW);
      end
      m_flush = flush_n;
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, 32'(valid_o), 32'(m_fetching));
      chk({tag, ".busy"},  32'(busy_o),  32'(m_fetching));
      chk({tag, ".addr"},  32'(addr_o),  32'(m_pc));
      chk({tag, ".flush"}, 32'(flush_o), 32'(m_flush));
   endtask

   task automatic idle_inputs();
      rst = 0; start_i = 0; stall_i = 0; halt_i = 0;
      redirect_valid_i = 0; redirect_addr_i = '0;
   endtask

   initial begin
      m_fetching = 0; m_pc = 0; m_flush = 0;
      idle_inputs();
      rst = 1;
      tick("reset");
      tick("reset2");
      chk("reset.addr_lit", 32'(addr_o), 32'h0);
      rst = 0;
      stall_i = 1; halt_i = 1; redirect_valid_i = 1; redirect_addr_i = 10'h55;
      tick("idle_ignore");
      idle_inputs();

      // Start, free-running 0..5
      start_i = 1;
      tick("start");
      start_i = 0;
      for (int unsigned i = 0; i < 5; i++) tick("run");
      chk("run.pc5", 32'(addr_o), 32'h5);

      // Stall three cycles, then release
      stall_i = 1;
      for (int unsigned i = 0; i < 3; i++) tick("stall");
      chk("stall.hold5", 32'(addr_o), 32'h5);
      stall_i = 0;
      tick("stall_rel");
      chk("stall.rel6", 32'(addr_o), 32'h6);
      tick("to7");

      // Redirect under stall
      stall_i = 1; redirect_valid_i = 1; redirect_addr_i = 10'h100;
      tick("redir_stall");
      chk("redir.addr_lit", 32'(addr_o), 32'h100);
      chk("redir.flush_lit", 32'(flush_o), 32'h1);
      redirect_valid_i = 0;
      tick("redir_hold");
      chk("redir.flush_clr", 32'(flush_o), 32'h0);
      stall_i = 0;
      tick("redir_rel");
      chk("redir.adv", 32'(addr_o), 32'h101);

      // Redirect beats halt; then halt, ignored redirect, restart
      redirect_valid_i = 1; redirect_addr_i = 10'h20; halt_i = 1;
      tick("redir_halt");
      chk("redir_halt.busy", 32'(busy_o), 32'h1);
      redirect_valid_i = 0;
      tick("halt");
      chk("halt.valid", 32'(valid_o), 32'h0);
      halt_i = 0; redirect_valid_i = 1; redirect_addr_i = 10'h2AA; stall_i = 1;
      tick("halted_ignore");
      chk("halted.frozen", 32'(addr_o), 32'h20);
      idle_inputs();
      start_i = 1; halt_i = 1;
      tick("restart");
      chk("restart.addr", 32'(addr_o), 32'h0);
      idle_inputs();

      // Back-to-back redirects, then wrap at the top address
      redirect_valid_i = 1; redirect_addr_i = 10'h3FE;
      tick("b2b_a");
      redirect_addr_i = 10'h3FF;
      tick("b2b_b");
      chk("b2b.flush", 32'(flush_o), 32'h1);
      redirect_valid_i = 0;
      tick("wrap");
      chk("wrap.zero", 32'(addr_o), 32'h0);
      chk("wrap.noflush", 32'(flush_o), 32'h0);

      // Reset mid-run with stall and redirect pending
      redirect_valid_i = 1; redirect_addr_i = 10'h44;
      tick("to44");
      stall_i = 1; redirect_addr_i = 10'h123; rst = 1;
      tick("rst_mid");
      chk("rst_mid.valid", 32'(valid_o), 32'h0);
      chk("rst_mid.addr", 32'(addr_o), 32'h0);
      idle_inputs();

      // Randomized traffic against the model
      for (int unsigned i = 0; i < 600; i++) begin
         rst              = ($urandom_range(0, 59) == 0);
         start_i          = ($urandom_range(0, 3) == 0);
         stall_i          = ($urandom_range(0, 2) == 0);
         halt_i           = ($urandom_range(0, 11) == 0);
         redirect_valid_i = ($urandom_range(0, 6) == 0);
         redirect_addr_i  = AW'($urandom);
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/insn_addr_gen.md
Name: insn_addr_gen

Overview:
- Upstream producer for the instruction fetcher: generates the fetch address stream (addr_o/valid_o) that drives the fetcher's addr_i/valid_i inputs.
- Honours the fetcher's back-pressure (stall_i ← fetcher stall_o).
- Accepts branch/jump redirects from execute and halt requests from decode; emits a one-cycle flush so downstream drops the stale in-flight instruction.
- Small three-state FSM around a registered program counter.

Parameters:
MEM_INSN_ADDR, 10, instruction-memory address width (from defs_insn.v)
RESET_PC, 0, start address loaded on reset and on start

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_i  input  1  begin or restart fetching at RESET_PC (IDLE/HALTED only)
stall_i  input  1  fetcher back-pressure; hold current address
halt_i  input  1  decode saw a halt instruction
redirect_valid_i  input  1  execute requests a control-flow change
redirect_addr_i  input  MEM_INSN_ADDR  redirect target
valid_o  output  1  addr_o is a live fetch request
addr_o  output  MEM_INSN_ADDR  fetch address to the fetcher
flush_o  output  1  squash the instruction currently leaving the fetcher
busy_o  output  1  high when state is RUN

Behaviour:
- One clock, clk. rst is synchronous, active-high, sampled on posedge clk.
- All outputs are registered; no input-to-output combinational path.
- Reset values: state=IDLE, pc=RESET_PC, addr_o=RESET_PC, valid_o=0, flush_o=0, busy_o=0.
- rst asserted mid-operation: these reset values apply the next cycle regardless of any other input.
- addr_o always equals the pc register.
- State IDLE:
  - valid_o=0; stall_i, halt_i and redirect are ignored.
  - start_i=1: → RUN, pc<=RESET_PC; valid_o=1 from the next cycle.
- State RUN (valid_o=1), per-cycle priority:
  1. redirect_valid_i=1:
     - pc<=redirect_addr_i, flush_o<=1 for exactly the next cycle, valid_o stays 1.
     - Applies even when stall_i=1; the fetcher picks up the new address once its stall releases.
     - halt_i in the same cycle is ignored, because the redirecting instruction is older.
  2. else halt_i=1: → HALTED, valid_o<=0, pc holds. Applies even when stall_i=1.
  3. else stall_i=1: pc holds, addr_o unchanged.
  4. else pc<=pc+1, modulo 2^MEM_INSN_ADDR; the maximum address wraps to 0 with no flag.
  - start_i is ignored in RUN.
- State HALTED:
  - valid_o=0; redirect_valid_i, stall_i and halt_i are ignored.
  - start_i=1: → RUN, pc<=RESET_PC.
- flush_o:
  - Asserted only in the cycle after an accepted redirect in RUN; otherwise 0.
  - Back-to-back redirects keep flush_o high on consecutive cycles, and pc takes the latest target.
- Latency:
  - start_i → first valid address: 1 cycle.
  - redirect_valid_i → addr_o=target: 1 cycle.
  - Fetched-instruction latency is the fetcher's concern (1 cycle after an unstalled address).
- stall_i while valid_o=0 has no effect.

Decomposition:
- MEM_INSN_ADDR and LEN_INSN come from the shared defs_insn.v parameter include.
- FSM state encodings (IDLE=2'd0, RUN=2'd1, HALTED=2'd2) go in a new shared include, defs_fetch.v, so decode/execute monitors can decode busy/state consistently.
- No sub-module: the incrementer and next-pc mux are inline.

Test Plan:
1. Reset, then start_i pulse, no stall, 4 cycles → valid_o=1; addr_o=0,1,2,3 on successive cycles; busy_o=1; flush_o=0.
2. RUN at pc=5; stall_i=1 for 3 cycles, then 0 → addr_o=5 held 3 cycles, then 6; valid_o stays 1.
3. pc=7 with redirect_valid_i=1, redirect_addr_i=0x100, stall_i=1 in the same cycle → next cycle addr_o=0x100 and flush_o=1 for one cycle; addr_o stays 0x100 while the stall persists and advances to 0x101 when it releases.
4. redirect_valid_i=1 (target 0x20) and halt_i=1 in the same cycle → state stays RUN, addr_o=0x20; then halt_i alone → valid_o=0, busy_o=0, addr_o frozen; redirect in HALTED ignored; start_i → addr_o=RESET_PC, valid_o=1.
5. Redirect to 0x3FF (MEM_INSN_ADDR=10), unstalled → addr_o=0x3FF then 0x000; no flush on the wrap.
6. rst=1 in RUN at pc=0x44 with stall_i=1 and a redirect pending → next cycle valid_o=0, addr_o=RESET_PC, flush_o=0, state IDLE.
